irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal 1..16).
REQ-002 SHALL have port s_axi_aclk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port s_axi_aresetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port src_irq  input  NUM_SRC  asynchronous level-high source requests.
REQ-005 SHALL have port wr_addr  input  4  register write byte address.
REQ-006 SHALL have ports wr_en / wr_data / wr_strb  input  1/32/4  write enable, data, byte enables.
REQ-007 SHALL have ports rd_addr / rd_en  input  4/1  read address and read-enable strobe.
REQ-008 SHALL have port rd_data  output  32  read data.
REQ-009 SHALL have port irq  output  1  level-high interrupt request to the CPU.

Function
REQ-010 SHALL pass each src_irq bit through a 2-FF synchronizer before any use.
REQ-011 SHALL implement registers: 0x0 IER (bits NUM_SRC-1:0 enables, bit31 GIE), RW, byte-strobed.
REQ-012 SHALL implement 0x4 IPR pending, read; a write clears each bit where wr_data=1 and the byte strobe is set (W1C).
REQ-013 SHALL implement 0x8 CLAIM, read-only: {bit31 valid, bits3:0 index of the lowest-numbered pending & enabled source}; valid=0 gives index 0.
REQ-014 SHALL implement 0xC EOI/STATUS: a write with wr_strb[0]=1 and wr_data[0]=1 is an EOI; a read returns {bits9:8 state, bits3:0 active_idx}.
REQ-015 SHALL drive rd_data combinationally from rd_addr, valid in the same cycle as rd_en; unused bits read 0; write/read side effects take place on the clock edge where wr_en/rd_en=1.
REQ-016 SHALL run an FSM with states IDLE=0, PEND=1, INSVC=2.
REQ-017 IDLE->PEND when GIE=1 and |(IPR & IER)=1.
REQ-018 PEND->IDLE when that condition drops before a claim (W1C or masking).
REQ-019 PEND->INSVC on rd_en at 0x8 with valid=1; the same edge clears that IPR bit and latches active_idx.
REQ-020 INSVC->IDLE on EOI; no nesting; new pends accumulate in IPR while in INSVC.
REQ-021 SHALL drive irq=1 exactly when state==PEND, registered, asserting one cycle after the PEND condition is sampled.
REQ-022 SHALL ignore a claim read outside PEND (no side effect, valid reported as computed); SHALL ignore an EOI outside INSVC.
REQ-023 When a set and a clear of the same IPR bit occur in the same cycle (W1C or claim), set SHALL win.
REQ-024 SHALL ignore writes to unused addresses and to IER bits at NUM_SRC..30.

Reset
REQ-025 On s_axi_aresetn=0, IER, IPR, synchronizers, edge history, active_idx and state SHALL clear asynchronously to 0/IDLE, and irq SHALL be 0.
REQ-026 A reset in PEND or INSVC SHALL abandon the in-service source; after release, no pend is generated until a new qualifying event.

Configuration
REQ-027 With IRQ_CTRL_EDGE_EN defined, an IPR bit SHALL set only on a 0->1 transition of the synchronized source.
REQ-028 Without IRQ_CTRL_EDGE_EN, an IPR bit SHALL set on every cycle the synchronized source is 1 (level capture), and the edge-history flops SHALL be absent.

Structure
REQ-029 Package irq_ctrl_pkg SHALL hold the register address constants (IER, IPR, CLAIM, EOI), the FSM state encodings, and the GIE bit position.
REQ-030 Sub-module irq_ctrl_sync SHALL contain the per-source synchronizer plus the optional edge detector, instantiated once per source.

Verification
REQ-031 IER=0x8000_0001, pulse src_irq[0] -> IPR=0x1 and irq=1 within 4 cycles; CLAIM reads 0x8000_0000; irq=0 next cycle; STATUS reads 0x200.
REQ-032 IER=0x8000_00FF, sources 5 and 2 asserted together -> CLAIM returns 0x8000_0002; after EOI, the FSM re-enters PEND and CLAIM returns 0x8000_0005.
REQ-033 In PEND, write IPR=0x1 -> state returns to IDLE and irq drops next cycle; a later EOI has no effect.
REQ-034 W1C of bit 3 in the same cycle as a new edge on src 3 -> IPR bit 3 remains 1.
REQ-035 GIE=0 with IER=0x0F and src 1 pending -> irq stays 0; setting GIE=1 -> irq=1 one cycle after the PEND condition is sampled.
REQ-036 Assert s_axi_aresetn=0 mid-INSVC -> irq=0, all registers 0 immediately; with src held high and IRQ_CTRL_EDGE_EN set -> no new pend after release.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encodings, GIE position.
package irq_ctrl_pkg;

  localparam logic [3:0] ADDR_IER   = 4'h0;
  localparam logic [3:0] ADDR_IPR   = 4'h4;
  localparam logic [3:0] ADDR_CLAIM = 4'h8;
  localparam logic [3:0] ADDR_EOI   = 4'hC;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_INSVC = 2'd2;

  localparam int GIE_BIT = 31;

endpackage

// File: rtl/irq_ctrl_sync.sv
// Per-source 2-FF synchronizer; with IRQ_CTRL_EDGE_EN defined it also detects rising edges,
// otherwise the synchronized level is passed straight through as the capture request.
module irq_ctrl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic capture
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], src};
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic       hist;
  logic [2:0] arm;

  // The chain refills from 0 after reset; arm masks that artificial rise so a
  // source held high through reset does not raise a fresh pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 1'b0;
      arm  <= '0;
    end else begin
      hist <= sync_q[1];
      arm  <= {arm[1:0], 1'b1};
    end
  end

  assign capture = arm[2] & sync_q[1] & ~hist;
`else
  assign capture = sync_q[1];
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: IER/IPR/CLAIM/EOI register file and a single-level IDLE/PEND/INSVC FSM.
// Define IRQ_CTRL_EDGE_EN for rising-edge capture of sources (level capture otherwise).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [3:0]         wr_addr,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_strb,
  input  logic [3:0]         rd_addr,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               irq
);

  logic [NUM_SRC-1:0] src_set, ier, ipr, pend_en, w1c_mask, claim_mask;
  logic               gie, claim_valid, claim_take, ier_wr, ipr_wr, eoi, pend_cond;
  logic [3:0]         claim_idx, active_idx;
  logic [1:0]         state, state_next;
  logic               unused_wr;

  assign unused_wr = ^{wr_data, wr_strb};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_ctrl_sync u_sync (
      .clk    (s_axi_aclk),
      .rst_n  (s_axi_aresetn),
      .src    (src_irq[g]),
      .capture(src_set[g])
    );
  end

  assign pend_en     = ipr & ier;
  assign claim_valid = |pend_en;
  assign pend_cond   = gie & claim_valid;

  always_comb begin
    claim_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend_en[i]) claim_idx = 4'(i);
    end
  end

  assign ier_wr     = wr_en && (wr_addr == ADDR_IER);
  assign ipr_wr     = wr_en && (wr_addr == ADDR_IPR);
  assign eoi        = wr_en && (wr_addr == ADDR_EOI) && wr_strb[0] && wr_data[0];
  assign claim_take = rd_en && (rd_addr == ADDR_CLAIM) && claim_valid && (state == ST_PEND);

  always_comb begin
    w1c_mask   = '0;
    claim_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w1c_mask[i]   = ipr_wr & wr_data[i] & wr_strb[i/8];
      claim_mask[i] = claim_take && (claim_idx == 4'(i));
    end
  end

  // A capture in the same cycle as a W1C or claim keeps the bit pending.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) ipr <= '0;
    else                ipr <= (ipr & ~(w1c_mask | claim_mask)) | src_set;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ier <= '0;
      gie <= 1'b0;
    end else if (ier_wr) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wr_strb[i/8]) ier[i] <= wr_data[i];
      end
      if (wr_strb[3]) gie <= wr_data[GIE_BIT];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pend_cond) state_next = ST_PEND;
      ST_PEND: begin
        if (claim_take)      state_next = ST_INSVC;
        else if (!pend_cond) state_next = ST_IDLE;
      end
      ST_INSVC: if (eoi) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // irq is a flop copy of the next state decode, so it tracks state == PEND exactly.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state      <= ST_IDLE;
      active_idx <= '0;
      irq        <= 1'b0;
    end else begin
      state <= state_next;
      irq   <= (state_next == ST_PEND);
      if (claim_take) active_idx <= claim_idx;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_IER: begin
        rd_data[NUM_SRC-1:0] = ier;
        rd_data[GIE_BIT]     = gie;
      end
      ADDR_IPR:   rd_data[NUM_SRC-1:0] = ipr;
      ADDR_CLAIM: begin
        rd_data[31]  = claim_valid;
        rd_data[3:0] = claim_idx;
      end
      ADDR_EOI: begin
        rd_data[9:8] = state;
        rd_data[3:0] = active_idx;
      end
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: settled-state reference model, read scoreboard, random ops.
module tb_irq_ctrl;

  localparam int NUM_SRC = 8;
  localparam logic [3:0] A_IER = 4'h0, A_IPR = 4'h4, A_CLAIM = 4'h8, A_EOI = 4'hC;
  localparam logic [1:0] M_IDLE = 2'd0, M_PEND = 2'd1, M_INSVC = 2'd2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_SRC-1:0] src_irq;
  logic [3:0]         wr_addr, rd_addr, wr_strb;
  logic               wr_en, rd_en, irq;
  logic [31:0]        wr_data, rd_data;

  irq_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .src_irq      (src_irq),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .irq          (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  // reference model: register contents once all activity has settled
  logic [NUM_SRC-1:0] m_ier, m_ipr, m_src;
  logic               m_gie;
  logic [1:0]         m_state;
  logic [3:0]         m_active;
  bit                 m_in_reset;

  function automatic logic [31:0] m_claim();
    for (int i = 0; i < NUM_SRC; i++)
      if (m_ipr[i] && m_ier[i]) return 32'h8000_0000 | 32'(i);
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(logic [3:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      A_IER: begin r[NUM_SRC-1:0] = m_ier; r[31] = m_gie; end
      A_IPR: r[NUM_SRC-1:0] = m_ipr;
      A_CLAIM: r = m_claim();
      A_EOI: r = {22'b0, m_state, 4'b0, m_active};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void m_settle();
    bit cond;
    if (m_in_reset) return;
`ifndef IRQ_CTRL_EDGE_EN
    m_ipr |= m_src;
`endif
    cond = m_gie && ((m_ipr & m_ier) != '0);
    for (int k = 0; k < 2; k++) begin
      if (m_state == M_IDLE && cond) m_state = M_PEND;
      else if (m_state == M_PEND && !cond) m_state = M_IDLE;
    end
  endfunction

  function automatic void m_write(logic [3:0] a, logic [31:0] d, logic [3:0] s);
    case (a)
      A_IER: begin
        for (int i = 0; i < NUM_SRC; i++) if (s[i/8]) m_ier[i] = d[i];
        if (s[3]) m_gie = d[31];
      end
      A_IPR: for (int i = 0; i < NUM_SRC; i++) if (d[i] && s[i/8]) m_ipr[i] = 1'b0;
      A_EOI: if (s[0] && d[0] && m_state == M_INSVC) m_state = M_IDLE;
      default: ;
    endcase
  endfunction

  function automatic void m_reset();
    m_ier = '0; m_ipr = '0; m_gie = 1'b0; m_state = M_IDLE; m_active = '0;
  endfunction

  // scoreboard monitor: every read strobe is checked against the oldest expectation
  always @(negedge clk) begin
    if (rd_en) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h required no read", rd_data);
      end else begin
        logic [31:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL %s: got %h required %h", t, rd_data, e);
        end
      end
    end
  end

  // driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic drive_write(logic [3:0] a, logic [31:0] d, logic [3:0] s);
    wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic op_write(logic [3:0] a, logic [31:0] d, logic [3:0] s);
    drive_write(a, d, s);
    m_write(a, d, s);
    cyc(3);
    m_settle();
    chk("irq_after_wr", {31'b0, irq}, {31'b0, m_state == M_PEND});
  endtask

  task automatic op_read(logic [3:0] a, string tag);
    logic [31:0] e;
    e = m_read(a);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    rd_addr = a; rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    if (a == A_CLAIM && e[31] && m_state == M_PEND && !m_in_reset) begin
      m_state  = M_INSVC;
      m_active = e[3:0];
      m_ipr[e[3:0]] = 1'b0;
    end
    chk("irq_after_rd_edge", {31'b0, irq}, {31'b0, m_state == M_PEND});
    cyc(3);
    m_settle();
    chk("irq_after_rd", {31'b0, irq}, {31'b0, m_state == M_PEND});
  endtask

  task automatic src_to(logic [NUM_SRC-1:0] v);
    src_irq = v;
`ifdef IRQ_CTRL_EDGE_EN
    m_ipr |= v & ~m_src;
`endif
    m_src = v;
    cyc(5);
    m_settle();
    chk("irq_after_src", {31'b0, irq}, {31'b0, m_state == M_PEND});
  endtask

  initial begin
    logic [31:0] r32;
    logic [3:0]  a;
    rst_n = 1'b0; src_irq = '0; wr_addr = '0; wr_en = 1'b0; wr_data = '0; wr_strb = '0;
    rd_addr = '0; rd_en = 1'b0;
    m_in_reset = 1'b1; m_src = '0; m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("irq_in_reset", {31'b0, irq}, 32'h0);
    op_read(A_IER, "rst_ier");
    op_read(A_IPR, "rst_ipr");
    op_read(A_CLAIM, "rst_claim");
    op_read(A_EOI, "rst_status");
    rst_n = 1'b1; m_in_reset = 1'b0;
    cyc(5);

    // single source pulse, claim, status, EOI
    op_write(A_IER, 32'h8000_0001, 4'hF);
    src_irq = 8'h01; cyc(1); src_irq = '0; cyc(3);
    chk("pulse_irq_4cyc", {31'b0, irq}, 32'h1);
    m_ipr |= 8'h01; m_settle();
    op_read(A_IPR, "pulse_ipr");
    op_read(A_CLAIM, "pulse_claim");
    op_read(A_EOI, "pulse_status");
    op_write(A_EOI, 32'h1, 4'h1);
    op_read(A_EOI, "eoi_status");

    // two sources: lowest index wins, the other follows after EOI
    op_write(A_IER, 32'h8000_00FF, 4'hF);
    src_to(8'h24); src_to(8'h00);
    op_read(A_CLAIM, "prio_claim_2");
    op_write(A_EOI, 32'h1, 4'h1);
    op_read(A_CLAIM, "prio_claim_5");
    op_write(A_EOI, 32'h1, 4'h1);

    // W1C while PEND drops the request; a stray EOI afterwards is ignored
    src_to(8'h01); src_to(8'h00);
    op_write(A_IPR, 32'h1, 4'hF);
    op_write(A_EOI, 32'h1, 4'h1);
    op_read(A_EOI, "stray_eoi_status");

    // W1C of bit 3 in the same cycle as a fresh capture on source 3
    op_write(A_IER, 32'h0000_00FF, 4'hF);
    src_to(8'h08); src_to(8'h00);
    src_irq = m_src | 8'h08;
    cyc(2);
    drive_write(A_IPR, 32'h8, 4'hF);
    m_ipr[3] = 1'b1; m_src = src_irq;
    cyc(3); m_settle();
    op_read(A_IPR, "set_beats_w1c");
    src_to(8'h00);
    op_write(A_IPR, 32'h8, 4'hF);
    op_read(A_IPR, "w1c_clears");

    // GIE gating and one-cycle irq latency after enabling
    op_write(A_IER, 32'h0000_000F, 4'hF);
    src_to(8'h02); src_to(8'h00);
    chk("gie_off_irq", {31'b0, irq}, 32'h0);
    drive_write(A_IER, 32'h8000_000F, 4'hF);
    m_write(A_IER, 32'h8000_000F, 4'hF);
    chk("gie_irq_same_cycle", {31'b0, irq}, 32'h0);
    cyc(1);
    chk("gie_irq_next_cycle", {31'b0, irq}, 32'h1);
    cyc(2); m_settle();
    op_read(A_CLAIM, "gie_claim");
    op_write(A_EOI, 32'h1, 4'h1);

    // reserved IER bits and unused addresses
    op_write(A_IER, 32'hFFFF_FFFF, 4'hF);
    op_read(A_IER, "ier_reserved");
    op_write(4'h2, 32'hFFFF_FFFF, 4'hF);
    op_read(4'h2, "unused_addr");

    // randomized operations against the model
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1: begin r32 = $urandom & $urandom; src_to(r32[NUM_SRC-1:0]); end
        2: begin
          r32 = $urandom;
          r32[31] = ($urandom_range(0, 3) != 0);
          op_write(A_IER, r32, 4'($urandom_range(0, 15)));
        end
        3: op_write(A_IPR, $urandom, 4'($urandom_range(0, 15)));
        4, 5: op_read(A_CLAIM, "rnd_claim");
        6: op_write(A_EOI, {31'($urandom), 1'($urandom_range(0, 3) != 0)}, 4'($urandom_range(0, 15)));
        7: begin
          case ($urandom_range(0, 2))
            0: op_read(A_IER, "rnd_ier");
            1: op_read(A_IPR, "rnd_ipr");
            default: op_read(A_EOI, "rnd_status");
          endcase
        end
        8: begin
          a = 4'($urandom_range(0, 15));
          if (a[1:0] == 2'b00) a = a + 4'd1;
          op_write(a, $urandom, 4'hF);
          op_read(a, "rnd_unused");
        end
        default: op_read(A_EOI, "rnd_status2");
      endcase
    end

    // reset in the middle of service with the source held high
    op_write(A_EOI, 32'h1, 4'h1);
    op_write(A_IER, 32'h8000_0001, 4'hF);
    src_to(8'h00); src_to(8'h01);
    op_read(A_CLAIM, "pre_rst_claim");
    op_read(A_EOI, "pre_rst_status");
    rst_n = 1'b0; m_in_reset = 1'b1; m_reset();
    #1;
    chk("irq_mid_rst", {31'b0, irq}, 32'h0);
    op_read(A_IER, "mid_rst_ier");
    op_read(A_IPR, "mid_rst_ipr");
    op_read(A_EOI, "mid_rst_status");
    rst_n = 1'b1; m_in_reset = 1'b0;
    cyc(6); m_settle();
    op_read(A_IPR, "post_rst_ipr");
    op_read(A_EOI, "post_rst_status");
    chk("post_rst_irq", {31'b0, irq}, {31'b0, m_state == M_PEND});

    cyc(2);
    chk("exp_q_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
